// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver: synchronises rx_in, majority-votes three mid-bit
// samples and emits one-cycle data_valid / frame_err strobes.
module uart_rx_oversampled #(
    parameter int data_width      = 8,
    parameter int clk_freq        = 50000000,
    parameter int baudrate        = 9600,
    parameter int oversample      = 16,
    parameter int tick_per_sample = clk_freq / (baudrate * oversample)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [data_width-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int PW = (tick_per_sample > 1) ? $clog2(tick_per_sample) : 1;
    localparam int SW = $clog2(oversample);
    localparam int BW = (data_width > 1) ? $clog2(data_width) : 1;
    localparam int M  = oversample / 2;

    localparam logic [PW-1:0] TICK_LAST = PW'(tick_per_sample - 1);
    localparam logic [SW-1:0] CNT_PRE   = SW'(M - 1);
    localparam logic [SW-1:0] CNT_MID   = SW'(M);
    localparam logic [SW-1:0] CNT_DEC   = SW'(M + 1);
    localparam logic [SW-1:0] CNT_LAST  = SW'(oversample - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(data_width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  v0_q, v0_d;
    logic                  v1_q, v1_d;
    logic [data_width-1:0] shreg_q, shreg_d;
    logic [data_width-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic rx_s;
    logic tick;
    logic vote;
    logic decide;
    logic bit_end;

    assign rx_s    = sync2_q;
    assign tick    = (presc_q == TICK_LAST);
    // Third vote sample is taken live on the decision tick itself.
    assign vote    = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    assign decide  = tick && (sample_cnt_q == CNT_DEC);
    assign bit_end = tick && (sample_cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        sync1_d      = rx_in;
        sync2_d      = sync1_q;
        presc_d      = tick ? '0 : presc_q + PW'(1);
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        v0_d         = v0_q;
        v1_d         = v1_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (tick) begin
            sample_cnt_d = sample_cnt_q + SW'(1);
            if (sample_cnt_q == CNT_PRE) v0_d = rx_s;
            if (sample_cnt_q == CNT_MID) v1_d = rx_s;
        end

        case (state_q)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_d      = START;
                    sample_cnt_d = '0;
                end
            end
            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (decide) shreg_d[bit_cnt_q] = vote;
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                    else                       bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (decide) begin
                    if (vote) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = BRK;
                    end
                end
            end
            BRK: begin
                if (tick && rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            presc_q      <= '0;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            presc_q      <= presc_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
        v0_q    <= v0_d;
        v1_q    <= v1_d;
        shreg_q <= shreg_d;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: 160 clk per bit, 10 clk per sample tick.
module tb_uart_rx_oversampled;

    localparam int BIT = 160;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         exp_valid = 0;
    int         exp_err = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_oversampled #(
        .data_width(8),
        .clk_freq  (1600000),
        .baudrate  (10000),
        .oversample(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_good(input logic [7:0] d);
        exp_t e;
        e.err = 1'b0;
        e.data = d;
        exp_q.push_back(e);
        exp_valid++;
        last_good = d;
    endtask

    task automatic expect_err();
        exp_t e;
        e.err = 1'b1;
        e.data = last_good;
        exp_q.push_back(e);
        exp_err++;
    endtask

    // spike_bit >= 0 puts a 10-clk low pulse around mid-bit of that data bit
    task automatic tx_frame(input logic [7:0] d, input logic stop, input int spike_bit);
        rx_in = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (i == spike_bit) begin
                hold(85);
                rx_in = 1'b0;
                hold(10);
                rx_in = d[i];
                hold(BIT - 95);
            end else begin
                hold(BIT);
            end
        end
        rx_in = stop;
        hold(BIT);
    endtask

    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err)) begin
            if (data_valid) n_valid++;
            if (frame_err) n_err++;
            if (data_valid && frame_err) check("strobe_excl", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, frame_err, data_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
                check("strobe_data", {24'd0, data_out}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold(5);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dout", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        hold(BIT);

        // 1: single frame
        expect_good(8'hA5);
        tx_frame(8'hA5, 1'b1, -1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_dout", {24'd0, data_out}, 32'h A5);
        hold(BIT);

        // 2: back-to-back
        expect_good(8'h00);
        tx_frame(8'h00, 1'b1, -1);
        expect_good(8'hFF);
        tx_frame(8'hFF, 1'b1, -1);
        check("t2_dout", {24'd0, data_out}, 32'hFF);
        hold(BIT);

        // 3: short low glitch
        rx_in = 1'b0;
        hold(30);
        check("t3_busy_hi", {31'd0, busy}, 32'd1);
        hold(10);
        rx_in = 1'b1;
        hold(100);
        check("t3_busy_lo", {31'd0, busy}, 32'd0);
        check("t3_dout", {24'd0, data_out}, 32'hFF);
        hold(BIT);
        expect_good(8'h3C);
        tx_frame(8'h3C, 1'b1, -1);
        hold(BIT);

        // 4: framing error followed by break
        expect_err();
        tx_frame(8'h55, 1'b0, -1);
        hold(3 * BIT);
        check("t4_busy_brk", {31'd0, busy}, 32'd1);
        rx_in = 1'b1;
        hold(2 * BIT);
        check("t4_busy_idle", {31'd0, busy}, 32'd0);
        check("t4_dout", {24'd0, data_out}, 32'h3C);
        expect_good(8'h81);
        tx_frame(8'h81, 1'b1, -1);
        hold(BIT);

        // 5: spike in data bit 3
        expect_good(8'hFF);
        tx_frame(8'hFF, 1'b1, 3);
        check("t5_dout", {24'd0, data_out}, 32'hFF);
        hold(BIT);

        // 6: reset mid data bit 4
        rx_in = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            hold(BIT);
        end
        rx_in = 1'b1;
        hold(BIT / 2);
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy_post", {31'd0, busy}, 32'd0);
        hold(2 * BIT);
        check("t6_no_strobe", n_valid + n_err, exp_valid + exp_err);
        expect_good(8'h12);
        tx_frame(8'h12, 1'b1, -1);
        check("t6_dout", {24'd0, data_out}, 32'h12);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        check("valid_count", n_valid, exp_valid);
        check("err_count", n_err, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
